// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational ALU between the EX stage (port 0)
// and an auxiliary unit (port 1). A round-robin arbiter picks at most one
// request per cycle, steers it onto the ALU inputs, and captures the result
// in a one-entry response register with valid/ready backpressure.
module alu_share_arb #(
  parameter int DW   = 32,
  parameter int OPW  = 5,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  input  logic [OPW-1:0]  req0_op,
  input  logic [TAGW-1:0] req0_tag,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  input  logic [OPW-1:0]  req1_op,
  input  logic [TAGW-1:0] req1_tag,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [OPW-1:0]  alu_op,
  input  logic [DW-1:0]   alu_out,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [TAGW-1:0] rsp_tag,
  output logic [DW-1:0]   rsp_data
);

  // Per-port views of the request interfaces so the arbiter can be generated.
  logic [1:0]      req_valid;
  logic [DW-1:0]   req_a   [2];
  logic [DW-1:0]   req_b   [2];
  logic [OPW-1:0]  req_op  [2];
  logic [TAGW-1:0] req_tag [2];
  logic [1:0]      grant;

  logic            last_grant_reg;
  logic            rsp_valid_reg;
  logic            rsp_id_reg;
  logic [TAGW-1:0] rsp_tag_reg;
  logic [DW-1:0]   rsp_data_reg;

  logic            can_accept;
  logic            any_grant;
  logic            grant_id;
  logic [TAGW-1:0] grant_tag;

  assign req_valid  = {req1_valid, req0_valid};
  assign req_a[0]   = req0_a;
  assign req_a[1]   = req1_a;
  assign req_b[0]   = req0_b;
  assign req_b[1]   = req1_b;
  assign req_op[0]  = req0_op;
  assign req_op[1]  = req1_op;
  assign req_tag[0] = req0_tag;
  assign req_tag[1] = req1_tag;

  // A new result may be captured only when the slot is empty or being drained,
  // and never during a flush.
  assign can_accept = ~flush & (~rsp_valid_reg | rsp_ready);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      // A port wins when it is alone, or when the other port holds the last grant.
      assign grant[gi] = can_accept & req_valid[gi] &
                         (~req_valid[1-gi] | (last_grant_reg == 1'(1 - gi)));
    end
  endgenerate

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign any_grant  = |grant;
  assign grant_id   = grant[1];

  // Steer the granted request onto the ALU; idle cycles hold the datapath at zero/NOP.
  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = '0;
    grant_tag = '0;
    if (grant[1]) begin
      alu_a     = req_a[1];
      alu_b     = req_b[1];
      alu_op    = req_op[1];
      grant_tag = req_tag[1];
    end else if (grant[0]) begin
      alu_a     = req_a[0];
      alu_b     = req_b[0];
      alu_op    = req_op[0];
      grant_tag = req_tag[0];
    end
  end

  // Response slot and fairness pointer; fill wins over drain so back-to-back has no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_tag_reg    <= '0;
      rsp_data_reg   <= '0;
      last_grant_reg <= 1'b1;
    end else if (flush) begin
      rsp_valid_reg  <= 1'b0;
    end else if (any_grant) begin
      rsp_valid_reg  <= 1'b1;
      rsp_id_reg     <= grant_id;
      rsp_tag_reg    <= grant_tag;
      rsp_data_reg   <= alu_out;
      last_grant_reg <= grant_id;
    end else if (rsp_ready) begin
      rsp_valid_reg  <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_tag   = rsp_tag_reg;
  assign rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_alu_share_arb.sv
// Testbench for alu_share_arb: table of directed vectors with hand-computed
// expectations, plus a hand-written asynchronous-reset sequence.
module tb_alu_share_arb;

  localparam int DW   = 32;
  localparam int OPW  = 5;
  localparam int TAGW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            req0_valid = 1'b0, req1_valid = 1'b0;
  logic            req0_ready, req1_ready;
  logic [DW-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [OPW-1:0]  req0_op = '0, req1_op = '0;
  logic [TAGW-1:0] req0_tag = '0, req1_tag = '0;
  logic [DW-1:0]   alu_a, alu_b, alu_out;
  logic [OPW-1:0]  alu_op;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic            rsp_id;
  logic [TAGW-1:0] rsp_tag;
  logic [DW-1:0]   rsp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference ALU: 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, anything else 0.
  always_comb begin
    case (alu_op)
      5'd1:    alu_out = alu_a + alu_b;
      5'd2:    alu_out = alu_a - alu_b;
      5'd3:    alu_out = alu_a & alu_b;
      5'd4:    alu_out = alu_a | alu_b;
      5'd5:    alu_out = alu_a ^ alu_b;
      default: alu_out = '0;
    endcase
  end

  alu_share_arb #(.DW(DW), .OPW(OPW), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_tag(req1_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_data(rsp_data)
  );

  typedef struct packed {
    logic        flush;
    logic        v0;
    logic [4:0]  op0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [3:0]  t0;
    logic        v1;
    logic [4:0]  op1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [3:0]  t1;
    logic        rr;
    logic        e_r0;
    logic        e_r1;
    logic [4:0]  e_op;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        e_v;
    logic        e_chk;
    logic        e_id;
    logic [3:0]  e_tag;
    logic [31:0] e_data;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic fl,
    input logic v0, input logic [4:0] op0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] t0,
    input logic v1, input logic [4:0] op1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] t1,
    input logic rr,
    input logic e_r0, input logic e_r1, input logic [4:0] e_op, input logic [31:0] e_a, input logic [31:0] e_b,
    input logic e_v, input logic e_chk, input logic e_id, input logic [3:0] e_tag, input logic [31:0] e_data);
    vec_t v;
    v.flush = fl;
    v.v0 = v0; v.op0 = op0; v.a0 = a0; v.b0 = b0; v.t0 = t0;
    v.v1 = v1; v.op1 = op1; v.a1 = a1; v.b1 = b1; v.t1 = t1;
    v.rr = rr;
    v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_op = e_op; v.e_a = e_a; v.e_b = e_b;
    v.e_v = e_v; v.e_chk = e_chk; v.e_id = e_id; v.e_tag = e_tag; v.e_data = e_data;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    flush = v.flush;
    req0_valid = v.v0; req0_op = v.op0; req0_a = v.a0; req0_b = v.b0; req0_tag = v.t0;
    req1_valid = v.v1; req1_op = v.op1; req1_a = v.a1; req1_b = v.b1; req1_tag = v.t1;
    rsp_ready = v.rr;
  endtask

  initial begin
    //           fl v0 op0  a0       b0      t0 v1 op1  a1       b1      t1  rr  r0 r1 op   alu_a     alu_b    v  chk id tag data
    // contended round robin after reset: grants 0,1,0,1
    vecs[0]  = mk(0, 1, 5'd1, 32'd5,   32'd7,  3, 1, 5'd2, 32'd20,  32'd3,  9, 1,  1, 0, 5'd1, 32'd5,    32'd7,   1, 1, 0, 3, 32'd12);
    vecs[1]  = mk(0, 1, 5'd5, 32'hFF,  32'h0F, 4, 1, 5'd2, 32'd20,  32'd3,  9, 1,  0, 1, 5'd2, 32'd20,   32'd3,   1, 1, 1, 9, 32'd17);
    vecs[2]  = mk(0, 1, 5'd5, 32'hFF,  32'h0F, 4, 1, 5'd3, 32'hF0,  32'h3C,10, 1,  1, 0, 5'd5, 32'hFF,   32'h0F,  1, 1, 0, 4, 32'hF0);
    vecs[3]  = mk(0, 1, 5'd4, 32'h100, 32'h1,  5, 1, 5'd3, 32'hF0,  32'h3C,10, 1,  0, 1, 5'd3, 32'hF0,   32'h3C,  1, 1, 1,10, 32'h30);
    // idle drain
    vecs[4]  = mk(0, 0, 5'd0, 32'd0,   32'd0,  0, 0, 5'd0, 32'd0,   32'd0,  0, 1,  0, 0, 5'd0, 32'd0,    32'd0,   0, 0, 0, 0, 32'd0);
    // port 0 alone: ADD 5+7 tag 3
    vecs[5]  = mk(0, 1, 5'd1, 32'd5,   32'd7,  3, 0, 5'd0, 32'd0,   32'd0,  0, 1,  1, 0, 5'd1, 32'd5,    32'd7,   1, 1, 0, 3, 32'd12);
    // backpressure for 3 cycles: no grant, response stable
    vecs[6]  = mk(0, 0, 5'd0, 32'd0,   32'd0,  0, 0, 5'd0, 32'd0,   32'd0,  0, 0,  0, 0, 5'd0, 32'd0,    32'd0,   1, 1, 0, 3, 32'd12);
    vecs[7]  = mk(0, 0, 5'd0, 32'd0,   32'd0,  0, 1, 5'd1, 32'd1,   32'd2,  7, 0,  0, 0, 5'd0, 32'd0,    32'd0,   1, 1, 0, 3, 32'd12);
    vecs[8]  = mk(0, 0, 5'd0, 32'd0,   32'd0,  0, 1, 5'd1, 32'd1,   32'd2,  7, 0,  0, 0, 5'd0, 32'd0,    32'd0,   1, 1, 0, 3, 32'd12);
    // drain and fill together, then back to back
    vecs[9]  = mk(0, 0, 5'd0, 32'd0,   32'd0,  0, 1, 5'd1, 32'd1,   32'd2,  7, 1,  0, 1, 5'd1, 32'd1,    32'd2,   1, 1, 1, 7, 32'd3);
    vecs[10] = mk(0, 0, 5'd0, 32'd0,   32'd0,  0, 1, 5'd2, 32'd10,  32'd4,  8, 1,  0, 1, 5'd2, 32'd10,   32'd4,   1, 1, 1, 8, 32'd6);
    // flush with a pending request: dropped, then granted next cycle
    vecs[11] = mk(1, 1, 5'd1, 32'd2,   32'd2,  2, 0, 5'd0, 32'd0,   32'd0,  0, 1,  0, 0, 5'd0, 32'd0,    32'd0,   0, 0, 0, 0, 32'd0);
    vecs[12] = mk(0, 1, 5'd1, 32'd2,   32'd2,  2, 0, 5'd0, 32'd0,   32'd0,  0, 1,  1, 0, 5'd1, 32'd2,    32'd2,   1, 1, 0, 2, 32'd4);
    // idle keeps last_grant=0, so the next contended cycle grants port 1
    vecs[13] = mk(0, 0, 5'd0, 32'd0,   32'd0,  0, 0, 5'd0, 32'd0,   32'd0,  0, 1,  0, 0, 5'd0, 32'd0,    32'd0,   0, 0, 0, 0, 32'd0);
    vecs[14] = mk(0, 1, 5'd3, 32'hFF,  32'h0F, 1, 1, 5'd4, 32'h10,  32'h01, 6, 1,  0, 1, 5'd4, 32'h10,   32'h01,  1, 1, 1, 6, 32'h11);
    vecs[15] = mk(0, 0, 5'd0, 32'd0,   32'd0,  0, 0, 5'd0, 32'd0,   32'd0,  0, 1,  0, 0, 5'd0, 32'd0,    32'd0,   0, 0, 0, 0, 32'd0);

    // Reset state
    #12;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_req0_ready", i), 32'(req0_ready), 32'(vecs[i].e_r0));
      check($sformatf("v%0d_req1_ready", i), 32'(req1_ready), 32'(vecs[i].e_r1));
      check($sformatf("v%0d_alu_op", i), 32'(alu_op), 32'(vecs[i].e_op));
      check($sformatf("v%0d_alu_a", i), alu_a, vecs[i].e_a);
      check($sformatf("v%0d_alu_b", i), alu_b, vecs[i].e_b);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_v));
      if (vecs[i].e_chk) begin
        check($sformatf("v%0d_rsp_id", i), 32'(rsp_id), 32'(vecs[i].e_id));
        check($sformatf("v%0d_rsp_tag", i), 32'(rsp_tag), 32'(vecs[i].e_tag));
        check($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].e_data);
      end
      $display("vec %0d: r0=%0b r1=%0b op=%0d rsp_valid=%0b id=%0b tag=%0d data=0x%0h",
               i, vecs[i].e_r0, vecs[i].e_r1, alu_op, rsp_valid, rsp_id, rsp_tag, rsp_data);
      @(negedge clk);
    end

    // Async reset while a response is held; port 0 grant first so last_grant=0 beforehand.
    drive(mk(0, 1, 5'd1, 32'd9, 32'd1, 11, 0, 5'd0, 32'd0, 32'd0, 0, 0,
             0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0));
    @(posedge clk);
    #1;
    check("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
    check("pre_reset_rsp_data", rsp_data, 32'd10);
    req0_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_rsp_id", 32'(rsp_id), 32'd0);
    check("async_rst_rsp_tag", 32'(rsp_tag), 32'd0);
    check("async_rst_rsp_data", rsp_data, 32'd0);
    $display("reset: rsp_valid=%0b id=%0b tag=%0d data=0x%0h", rsp_valid, rsp_id, rsp_tag, rsp_data);
    @(negedge clk);
    rst = 1'b0;
    drive(mk(0, 1, 5'd1, 32'd1, 32'd1, 12, 1, 5'd2, 32'd8, 32'd3, 13, 1,
             0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0));
    #1;
    check("post_rst_req0_ready", 32'(req0_ready), 32'd1);
    check("post_rst_req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk);
    #1;
    check("post_rst_rsp_id", 32'(rsp_id), 32'd0);
    check("post_rst_rsp_tag", 32'(rsp_tag), 32'd12);
    check("post_rst_rsp_data", rsp_data, 32'd2);
    $display("post-reset contended: rsp_id=%0b tag=%0d data=0x%0h", rsp_id, rsp_tag, rsp_data);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
